// File: rtl/serial_addsub_pkg.sv
// ---------------------------------------------------------------------------
// serial_addsub_pkg
// Shared encodings for the bit-serial adder/subtractor.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package serial_addsub_pkg;

    // Controller states
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    // Operation select carried on the mode input
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

endpackage

`default_nettype wire

// File: rtl/serial_addsub_fas_bit.sv
// ---------------------------------------------------------------------------
// fas_bit (plus xor2/and2/or2 gate cells)
// Combinational 1-bit add/subtract cell: b is inverted when m=1, then a
// ripple full adder is formed from two-input gates.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module xor2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i ^ b_i;
endmodule

module and2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i & b_i;
endmodule

module or2 (
    input  logic a_i,
    input  logic b_i,
    output logic y_o
);
    assign y_o = a_i | b_i;
endmodule

module fas_bit (
    input  logic m,
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic w_bx;     // b conditionally inverted for subtraction
    logic w_p;      // propagate
    logic w_g;      // generate
    logic w_t;      // propagated carry

    xor2 u_xb (.a_i(b),   .b_i(m),   .y_o(w_bx));
    xor2 u_xp (.a_i(a),   .b_i(w_bx), .y_o(w_p));
    xor2 u_xs (.a_i(w_p), .b_i(cin), .y_o(s));
    and2 u_ag (.a_i(a),   .b_i(w_bx), .y_o(w_g));
    and2 u_at (.a_i(w_p), .b_i(cin), .y_o(w_t));
    or2  u_oc (.a_i(w_g), .b_i(w_t), .y_o(cout));
endmodule

`default_nettype wire

// File: rtl/serial_addsub.sv
// ---------------------------------------------------------------------------
// serial_addsub
// Bit-serial WIDTH-bit adder/subtractor. One bit per clock, LSB first,
// through a single fas_bit cell with a registered carry. Result and flags
// are registered and held until the next completion.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_addsub
    import serial_addsub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int               CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e             state_q,  state_d;
    logic [CNT_W-1:0]   cnt_q,    cnt_d;
    logic [WIDTH-1:0]   a_sh_q,   a_sh_d;
    logic [WIDTH-1:0]   b_sh_q,   b_sh_d;
    // Holds the sum bits produced so far; the final bit is appended on the
    // last cycle, so one fewer bit of storage is enough.
    logic [WIDTH-2:0]   res_sh_q, res_sh_d;
    logic               mode_q,   mode_d;
    logic               carry_q,  carry_d;
    logic               busy_q,   busy_d;
    logic               done_q,   done_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               cout_q,   cout_d;
    logic               ovf_q,    ovf_d;
    logic               zero_q,   zero_d;

    logic               w_sum;
    logic               w_carry;
    logic [WIDTH-1:0]   w_res_next;

    fas_bit u_cell (
        .m    (mode_q),
        .a    (a_sh_q[0]),
        .b    (b_sh_q[0]),
        .cin  (carry_q),
        .s    (w_sum),
        .cout (w_carry)
    );

    assign w_res_next = {w_sum, res_sh_q};

    // Next-state logic: accept in IDLE, one bit per cycle in RUN.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        mode_d   = mode_q;
        carry_d  = carry_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        cout_d   = cout_q;
        ovf_d    = ovf_q;
        zero_d   = zero_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    a_sh_d  = a;
                    b_sh_d  = b;
                    mode_d  = mode;
                    // Subtract is A + ~B + 1: the +1 enters as initial carry.
                    carry_d = (mode == MODE_SUB);
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                a_sh_d   = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d   = {1'b0, b_sh_q[WIDTH-1:1]};
                res_sh_d = w_res_next[WIDTH-1:1];
                carry_d  = w_carry;
                cnt_d    = cnt_q + 1'b1;
                if (cnt_q == CNT_LAST) begin
                    state_d  = ST_IDLE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    result_d = w_res_next;
                    cout_d   = w_carry;
                    // carry_q is the carry into the MSB on this final cycle
                    ovf_d    = carry_q ^ w_carry;
                    zero_d   = (w_res_next == '0);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            mode_q   <= MODE_ADD;
            carry_q  <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
            cout_q   <= 1'b0;
            ovf_q    <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            mode_q   <= mode_d;
            carry_q  <= carry_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            ovf_q    <= ovf_d;
            zero_q   <= zero_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign cout   = cout_q;
    assign ovf    = ovf_q;
    assign zero   = zero_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_addsub.sv
// ---------------------------------------------------------------------------
// tb_serial_addsub
// Self-checking bench for serial_addsub at WIDTH = 8, 2 and 32.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_serial_addsub;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  st;
    logic        mode;
    logic [31:0] a_bus, b_bus;

    logic        busy8, done8, cout8, ovf8, zero8;
    logic [7:0]  res8;
    logic        busy2, done2, cout2, ovf2, zero2;
    logic [1:0]  res2;
    logic        busy32, done32, cout32, ovf32, zero32;
    logic [31:0] res32;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    serial_addsub #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .start(st[0]), .mode(mode),
        .a(a_bus[7:0]), .b(b_bus[7:0]),
        .busy(busy8), .done(done8), .result(res8),
        .cout(cout8), .ovf(ovf8), .zero(zero8)
    );

    serial_addsub #(.WIDTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(st[1]), .mode(mode),
        .a(a_bus[1:0]), .b(b_bus[1:0]),
        .busy(busy2), .done(done2), .result(res2),
        .cout(cout2), .ovf(ovf2), .zero(zero2)
    );

    serial_addsub #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset), .start(st[2]), .mode(mode),
        .a(a_bus), .b(b_bus),
        .busy(busy32), .done(done32), .result(res32),
        .cout(cout32), .ovf(ovf32), .zero(zero32)
    );

    typedef struct {
        logic       m;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] r;
        logic       co;
        logic       ov;
        logic       z;
    } vec_t;

    vec_t tbl [8];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int width_of(input int sel);
        case (sel)
            0:       return 8;
            1:       return 2;
            default: return 32;
        endcase
    endfunction

    task automatic get(input int sel, output logic [31:0] r, output logic co,
                       output logic ov, output logic z, output logic bz, output logic dn);
        case (sel)
            0: begin r = {24'h0, res8}; co = cout8; ov = ovf8; z = zero8; bz = busy8; dn = done8; end
            1: begin r = {30'h0, res2}; co = cout2; ov = ovf2; z = zero2; bz = busy2; dn = done2; end
            default: begin r = res32; co = cout32; ov = ovf32; z = zero32; bz = busy32; dn = done32; end
        endcase
    endtask

    // Arithmetic reference: plain integer add/sub with signed range check.
    task automatic ref_model(input int w, input logic [31:0] av, input logic [31:0] bv,
                             input logic m, output logic [31:0] r, output logic co,
                             output logic ov, output logic z);
        longint modv = longint'(1) << w;
        longint half = longint'(1) << (w - 1);
        longint ua   = longint'(av) % modv;
        longint ub   = longint'(bv) % modv;
        longint sa   = (ua >= half) ? ua - modv : ua;
        longint sb   = (ub >= half) ? ub - modv : ub;
        longint ures = m ? (ua - ub) : (ua + ub);
        longint sres = m ? (sa - sb) : (sa + sb);
        longint rr   = ((ures % modv) + modv) % modv;
        r  = 32'(rr);
        co = m ? (ua >= ub) : (ures >= modv);
        ov = (sres < -half) || (sres > half - 1);
        z  = (rr == 0);
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic do_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                         input logic m, output logic [31:0] r, output logic co,
                         output logic ov, output logic z, output int lat, output int bcnt);
        logic bz, dn;
        @(negedge clk);
        a_bus = av; b_bus = bv; mode = m; st[sel] = 1'b1;
        @(posedge clk); #1;
        st[sel] = 1'b0;
        a_bus = $urandom; b_bus = $urandom; mode = 1'($urandom);
        lat = 0; bcnt = 0;
        get(sel, r, co, ov, z, bz, dn);
        if (bz) bcnt++;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            get(sel, r, co, ov, z, bz, dn);
            if (dn) break;
            if (bz) bcnt++;
        end
    endtask

    initial begin
        logic [31:0] r, er, prev, r1, r2;
        logic co, ov, z, eco, eov, ez;
        int lat, bcnt, d1, d2, extra, stable, ndone;

        tbl[0] = '{1'b0, 8'h5A, 8'h33, 8'h8D, 1'b0, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 8'h10, 8'h20, 8'hF0, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 8'h80, 8'h01, 8'h7F, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b0, 8'hFF, 8'h01, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 8'h7F, 8'h01, 8'h80, 1'b0, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h05, 8'h05, 8'h00, 1'b1, 1'b0, 1'b1};
        tbl[6] = '{1'b1, 8'h00, 8'h01, 8'hFF, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; st = 3'b000; mode = 1'b0; a_bus = '0; b_bus = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {26'h0, busy8, done8, cout8, ovf8, zero8, (res8 != 8'h00)}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Directed vectors
        for (int i = 0; i < 8; i++) begin
            do_op(0, {24'h0, tbl[i].a}, {24'h0, tbl[i].b}, tbl[i].m, r, co, ov, z, lat, bcnt);
            chk($sformatf("vec%0d_result", i), r, {24'h0, tbl[i].r});
            chk($sformatf("vec%0d_cout", i), {31'h0, co}, {31'h0, tbl[i].co});
            chk($sformatf("vec%0d_ovf", i), {31'h0, ov}, {31'h0, tbl[i].ov});
            chk($sformatf("vec%0d_zero", i), {31'h0, z}, {31'h0, tbl[i].z});
            chk($sformatf("vec%0d_latency", i), lat, 8);
            if (i == 0) chk("vec0_busy_cycles", bcnt, 8);
        end

        // start during RUN ignored; start held through done accepted back-to-back
        prev = {24'h0, res8};
        @(negedge clk);
        a_bus = 32'h11; b_bus = 32'h22; mode = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        a_bus = 32'h40; b_bus = 32'h03; mode = 1'b1;
        d1 = -1; d2 = -1; extra = 0; stable = 1; r1 = '0; r2 = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (k == 9) st[0] = 1'b0;
            if (done8) begin
                if (d1 < 0) begin d1 = k; r1 = {24'h0, res8}; end
                else if (d2 < 0) begin d2 = k; r2 = {24'h0, res8}; end
                else extra++;
            end
            if (k < 8 && {24'h0, res8} !== prev) stable = 0;
        end
        chk("b2b_first_done_edge", d1, 8);
        chk("b2b_first_result", r1, 32'h33);
        chk("b2b_done_spacing", d2 - d1, 9);
        chk("b2b_second_result", r2, 32'h3D);
        chk("b2b_hold_during_run", stable, 1);
        chk("b2b_extra_done", extra, 0);

        // Reset in the middle of RUN discards the operation
        @(negedge clk);
        a_bus = 32'h5A; b_bus = 32'h33; mode = 1'b0; st[0] = 1'b1;
        @(posedge clk); #1;
        st[0] = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        chk("midrun_reset_outputs", {26'h0, busy8, done8, cout8, ovf8, zero8, (res8 != 8'h00)}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        ndone = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (done8) ndone++;
        end
        chk("midrun_reset_no_done", ndone, 0);
        do_op(0, 32'h01, 32'h02, 1'b0, r, co, ov, z, lat, bcnt);
        chk("after_reset_result", r, 32'h03);
        chk("after_reset_latency", lat, 8);

        // Randomized sweep over the three widths
        for (int i = 0; i < 1000; i++) begin
            int sel;
            logic [31:0] av, bv;
            logic m;
            sel = (i < 400) ? 0 : ((i < 600) ? 1 : 2);
            av = $urandom;
            bv = $urandom;
            m  = 1'($urandom);
            if (sel == 0) begin av = av & 32'hFF; bv = bv & 32'hFF; end
            if (sel == 1) begin av = av & 32'h3;  bv = bv & 32'h3;  end
            do_op(sel, av, bv, m, r, co, ov, z, lat, bcnt);
            ref_model(width_of(sel), av, bv, m, er, eco, eov, ez);
            chk($sformatf("rnd%0d_w%0d_result", i, width_of(sel)), r, er);
            chk($sformatf("rnd%0d_w%0d_cout", i, width_of(sel)), {31'h0, co}, {31'h0, eco});
            chk($sformatf("rnd%0d_w%0d_ovf", i, width_of(sel)), {31'h0, ov}, {31'h0, eov});
            chk($sformatf("rnd%0d_w%0d_zero", i, width_of(sel)), {31'h0, z}, {31'h0, ez});
            chk($sformatf("rnd%0d_w%0d_latency", i, width_of(sel)), lat, width_of(sel));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
